// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared constants and state encoding for the rv32i load/store unit
package rv32i_pkg;

    localparam int XLEN = 32;

    // Load funct3 codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/rv32i_lsu_if.sv
// rtl/rv32i_lsu_if.sv - core request/response and memory bus signals of the load/store unit
interface rv32i_lsu_if #(
    parameter int XLEN = 32
);
    logic            req_i;
    logic            we_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] wdata_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] rdata_o;
    logic            misaligned_o;
    logic            fault_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [3:0]      mem_wmask_o;
    logic            mem_read_o;
    logic            mem_write_o;
    logic [XLEN-1:0] mem_data_i;
    logic            mem_ack_i;
    logic            illegal_access_i;

    // LSU side
    modport slave (
        input  req_i, we_i, funct3_i, addr_i, wdata_i,
        input  mem_data_i, mem_ack_i, illegal_access_i,
        output busy_o, done_o, rdata_o, misaligned_o, fault_o,
        output mem_addr_o, mem_wdata_o, mem_wmask_o, mem_read_o, mem_write_o
    );

    // Core / memory-map side
    modport master (
        output req_i, we_i, funct3_i, addr_i, wdata_i,
        output mem_data_i, mem_ack_i, illegal_access_i,
        input  busy_o, done_o, rdata_o, misaligned_o, fault_o,
        input  mem_addr_o, mem_wdata_o, mem_wmask_o, mem_read_o, mem_write_o
    );
endinterface

// File: rtl/rv32i_lsu_align.sv
// rtl/rv32i_lsu_align.sv - byte-lane alignment, legality checks and load extension
module rv32i_lsu_align
    import rv32i_pkg::*;
(
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [3:0]      wmask_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misaligned_o,
    output logic            illegal_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] shifted;

    // Request side: lane mask, replicated store data and legality of the access
    always_comb begin
        wmask_o      = 4'b0000;
        wdata_o      = '0;
        illegal_o    = 1'b0;
        misaligned_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
        if (we_i) begin
            case (funct3_i)
                SB: begin
                    wmask_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                SH: begin
                    wmask_o = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                SW: begin
                    wmask_o = 4'b1111;
                    wdata_o = wdata_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LB, LH, LW, LBU, LHU: illegal_o = 1'b0;
                default:              illegal_o = 1'b1;
            endcase
        end
    end

    // Load side: pull the addressed lane down to bit 0 and extend it
    always_comb begin
        shifted = mem_data_i >> {ld_off_i, 3'b000};
        case (ld_funct3_i)
            LB:      ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            LH:      ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     ld_data_o = {24'h000000, shifted[7:0]};
            LHU:     ld_data_o = {16'h0000, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - single-outstanding load/store unit with timeout and trap reporting
module rv32i_lsu
    import rv32i_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    rv32i_lsu_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      mask_q, mask_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            mis_q, mis_d;
    logic            flt_q, flt_d;

    logic [3:0]      al_mask;
    logic [XLEN-1:0] al_wdata;
    logic            al_mis;
    logic            al_ill;
    logic [XLEN-1:0] ld_data;

    rv32i_lsu_align u_align (
        .we_i         (bus.we_i),
        .funct3_i     (bus.funct3_i),
        .addr_lo_i    (bus.addr_i[1:0]),
        .wdata_i      (bus.wdata_i),
        .wmask_o      (al_mask),
        .wdata_o      (al_wdata),
        .misaligned_o (al_mis),
        .illegal_o    (al_ill),
        .ld_funct3_i  (f3_q),
        .ld_off_i     (off_q),
        .mem_data_i   (bus.mem_data_i),
        .ld_data_o    (ld_data)
    );

    // State and datapath registers; reset drops the strobes immediately
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            flt_q   <= flt_d;
        end
    end

    // Next-state: accept in IDLE, wait for ack/fault/timeout, pulse done once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        flt_d   = flt_q;
        case (state_q)
            LSU_IDLE: begin
                mis_d = 1'b0;
                flt_d = 1'b0;
                if (bus.req_i) begin
                    if (al_ill || al_mis) begin
                        // illegal funct3 wins over misalignment
                        flt_d   = al_ill;
                        mis_d   = ~al_ill;
                        rdata_d = '0;
                        state_d = LSU_RESP;
                    end else begin
                        addr_d  = {bus.addr_i[XLEN-1:2], 2'b00};
                        wdata_d = al_wdata;
                        mask_d  = al_mask;
                        f3_d    = bus.funct3_i;
                        off_d   = bus.addr_i[1:0];
                        rd_d    = ~bus.we_i;
                        wr_d    = bus.we_i;
                        cnt_d   = '0;
                        state_d = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                if (bus.illegal_access_i) begin
                    flt_d   = 1'b1;
                    rdata_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = LSU_RESP;
                end else if (bus.mem_ack_i) begin
                    rdata_d = wr_q ? '0 : ld_data;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = LSU_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    flt_d   = 1'b1;
                    rdata_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign bus.busy_o       = (state_q != LSU_IDLE);
    assign bus.done_o       = (state_q == LSU_RESP);
    assign bus.rdata_o      = rdata_q;
    assign bus.misaligned_o = mis_q & bus.done_o;
    assign bus.fault_o      = flt_q & bus.done_o;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.mem_wmask_o  = mask_q;
    assign bus.mem_read_o   = rd_q;
    assign bus.mem_write_o  = wr_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb/tb_rv32i_lsu.sv - scoreboard bench for the rv32i load/store unit
module tb_rv32i_lsu;

    typedef struct {
        string       name;
        logic        mis;
        logic        flt;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst_n;

    rv32i_lsu_if #(.XLEN(32)) bus ();

    rv32i_lsu #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    exp_t exp_q[$];
    exp_t e;
    int   st_checks = 0;
    int   st_fail   = 0;
    int   mon_checks = 0;
    int   mon_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        st_checks++;
        if (act !== exp) begin
            st_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        mon_checks++;
        if (act !== exp) begin
            mon_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_resp(input string nm, input logic mis, input logic flt, input logic [31:0] rd);
        exp_t x;
        x.name  = nm;
        x.mis   = mis;
        x.flt   = flt;
        x.rdata = rd;
        exp_q.push_back(x);
    endtask

    // Present a request for one cycle; returns at the negedge after it was sampled
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mdata);
        @(negedge clk);
        bus.req_i      = 1'b1;
        bus.we_i       = we;
        bus.funct3_i   = f3;
        bus.addr_i     = addr;
        bus.wdata_i    = wdata;
        bus.mem_data_i = mdata;
        @(negedge clk);
        bus.req_i = 1'b0;
    endtask

    // Hold off the ack for n WAIT cycles, then ack for one cycle
    task automatic ack_after(input int n);
        repeat (n) @(negedge clk);
        bus.mem_ack_i = 1'b1;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
    endtask

    // Monitor: compare every done pulse against the oldest expected response
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            if (exp_q.size() == 0) begin
                mon_checks++;
                mon_fail++;
                $display("FAIL unexpected_done: got done_o=1 expected no response");
            end else begin
                e = exp_q.pop_front();
                mchk({e.name, "_misaligned"}, {31'd0, bus.misaligned_o}, {31'd0, e.mis});
                mchk({e.name, "_fault"}, {31'd0, bus.fault_o}, {31'd0, e.flt});
                mchk({e.name, "_rdata"}, bus.rdata_o, e.rdata);
            end
        end
        if (!bus.done_o && (bus.misaligned_o || bus.fault_o)) begin
            mon_checks++;
            mon_fail++;
            $display("FAIL flags_without_done: got mis=%b fault=%b expected 0", bus.misaligned_o, bus.fault_o);
        end
    end

    initial begin
        int hi;
        rst_n                = 1'b0;
        bus.req_i            = 1'b0;
        bus.we_i             = 1'b0;
        bus.funct3_i         = 3'b000;
        bus.addr_i           = '0;
        bus.wdata_i          = '0;
        bus.mem_data_i       = '0;
        bus.mem_ack_i        = 1'b0;
        bus.illegal_access_i = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst_mask", {28'd0, bus.mem_wmask_o}, 32'd0);
        chk("rst_read", {31'd0, bus.mem_read_o}, 32'd0);
        chk("rst_write", {31'd0, bus.mem_write_o}, 32'd0);
        rst_n = 1'b1;

        // SB to lane 3, ack after two WAIT cycles
        expect_resp("sb", 1'b0, 1'b0, 32'h0000_0000);
        issue(1'b1, 3'b000, 32'h0001_0003, 32'h0000_00A5, 32'h0);
        chk("sb_addr", bus.mem_addr_o, 32'h0001_0000);
        chk("sb_mask", {28'd0, bus.mem_wmask_o}, 32'h8);
        chk("sb_wdata", bus.mem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_write", {31'd0, bus.mem_write_o}, 32'd1);
        chk("sb_read", {31'd0, bus.mem_read_o}, 32'd0);
        chk("sb_busy", {31'd0, bus.busy_o}, 32'd1);
        ack_after(2);

        // LB / LBU of byte 2 with immediate ack
        expect_resp("lb", 1'b0, 1'b0, 32'hFFFF_FF80);
        issue(1'b0, 3'b000, 32'h0001_0002, 32'h0, 32'h1280_FF34);
        chk("lb_read", {31'd0, bus.mem_read_o}, 32'd1);
        chk("lb_mask", {28'd0, bus.mem_wmask_o}, 32'd0);
        ack_after(0);
        chk("lb_done_latency", {31'd0, bus.done_o}, 32'd1);
        chk("lb_read_dropped", {31'd0, bus.mem_read_o}, 32'd0);
        expect_resp("lbu", 1'b0, 1'b0, 32'h0000_0080);
        issue(1'b0, 3'b100, 32'h0001_0002, 32'h0, 32'h1280_FF34);
        ack_after(0);

        // SH to upper half, then LH / LHU of the upper half
        expect_resp("sh", 1'b0, 1'b0, 32'h0000_0000);
        issue(1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 32'h0);
        chk("sh_mask", {28'd0, bus.mem_wmask_o}, 32'hC);
        chk("sh_wdata", bus.mem_wdata_o, 32'hABCD_ABCD);
        chk("sh_addr", bus.mem_addr_o, 32'h0000_0040);
        ack_after(1);
        expect_resp("lh", 1'b0, 1'b0, 32'hFFFF_8001);
        issue(1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'h8001_7F00);
        ack_after(0);
        expect_resp("lhu", 1'b0, 1'b0, 32'h0000_8001);
        issue(1'b0, 3'b101, 32'h0000_0042, 32'h0, 32'h8001_7F00);
        ack_after(0);

        // LW with a slow ack
        expect_resp("lw", 1'b0, 1'b0, 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D);
        chk("lw_addr", bus.mem_addr_o, 32'h0000_0104);
        ack_after(3);

        // Misaligned LH and SW: response on the second cycle, no strobe
        expect_resp("lh_mis", 1'b1, 1'b0, 32'h0);
        issue(1'b0, 3'b001, 32'h0001_0001, 32'h0, 32'h0);
        chk("lh_mis_done", {31'd0, bus.done_o}, 32'd1);
        chk("lh_mis_strobe", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
        expect_resp("sw_mis", 1'b1, 1'b0, 32'h0);
        issue(1'b1, 3'b010, 32'h0002_0002, 32'h1111_2222, 32'h0);
        chk("sw_mis_done", {31'd0, bus.done_o}, 32'd1);
        chk("sw_mis_strobe", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);

        // Illegal funct3 for a load, and a store that is also misaligned
        expect_resp("ld_f3_011", 1'b0, 1'b1, 32'h0);
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0);
        chk("ld_f3_strobe", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
        expect_resp("st_f3_mis", 1'b0, 1'b1, 32'h0);
        issue(1'b1, 3'b011, 32'h0000_0001, 32'h0, 32'h0);

        // LW to an unmapped region
        expect_resp("lw_illegal", 1'b0, 1'b1, 32'h0);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h5555_5555);
        bus.illegal_access_i = 1'b1;
        @(negedge clk);
        bus.illegal_access_i = 1'b0;

        // LW timeout with a second request arriving during WAIT
        expect_resp("lw_timeout", 1'b0, 1'b1, 32'h0);
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done_o) break;
            if (bus.mem_read_o) hi++;
            if (k == 0) begin
                bus.req_i    = 1'b1;
                bus.we_i     = 1'b1;
                bus.funct3_i = 3'b010;
                bus.addr_i   = 32'h0000_0400;
            end
            if (k == 1) bus.req_i = 1'b0;
            @(negedge clk);
        end
        chk("timeout_strobe_cycles", hi, 32'd4);
        @(negedge clk);
        chk("timeout_then_idle", {31'd0, bus.busy_o}, 32'd0);
        chk("second_req_ignored", {31'd0, bus.mem_write_o}, 32'd0);

        // Reset during WAIT
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0);
        chk("pre_reset_read", {31'd0, bus.mem_read_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_read", {31'd0, bus.mem_read_o}, 32'd0);
        chk("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("reset_done", {31'd0, bus.done_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_resp("lw_after_reset", 1'b0, 1'b0, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF);
        ack_after(1);

        repeat (3) @(negedge clk);
        chk("responses_outstanding", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed",
                 (st_checks + mon_checks) - (st_fail + mon_fail), st_checks + mon_checks);
        $finish;
    end

endmodule
